stream_dispatch_1to2: RTL and testbench

Registered, handshaked 1-to-2 dispatcher for the demux path. It routes a valid/ready input stream to one of two output streams. The destination comes either from an explicit per-beat select or from an internal round-robin pointer. Each output has a 2-entry buffer, so one stalled consumer never corrupts or drops data. The block feeds the two downstream consumers and keeps a per-output beat count for debug.

---
 rtl/stream_dispatch_1to2_pkg.sv | 14 +
 rtl/stream_dispatch_1to2_if.sv | 30 +++
 rtl/dispatch_fifo2.sv | 62 ++++++
 rtl/stream_dispatch_1to2.sv | 73 +++++++
 tb/tb_stream_dispatch_1to2.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/stream_dispatch_1to2_pkg.sv
// Shared types and defaults for the 1-to-2 stream dispatcher.
package dispatch_pkg;

  typedef enum logic {
    DEST0 = 1'b0,
    DEST1 = 1'b1
  } dest_t;

  localparam int MODE_SEL   = 0;
  localparam int MODE_RR    = 1;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_CNT_W  = 16;

endpackage

// File: rtl/stream_dispatch_1to2_if.sv
// Handshake bundle between the dispatcher and its producer/consumers.
interface stream_dispatch_1to2_if
  import dispatch_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CNT_W  = DEF_CNT_W
);

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_sel;
  logic [1:0]        out_valid;
  logic [1:0]        out_ready;
  logic [DATA_W-1:0] out_data0;
  logic [DATA_W-1:0] out_data1;
  logic [CNT_W-1:0]  cnt0;
  logic [CNT_W-1:0]  cnt1;

  modport slave (
    input  in_valid, in_data, in_sel, out_ready,
    output in_ready, out_valid, out_data0, out_data1, cnt0, cnt1
  );

  modport master (
    output in_valid, in_data, in_sel, out_ready,
    input  in_ready, out_valid, out_data0, out_data1, cnt0, cnt1
  );

endinterface

// File: rtl/dispatch_fifo2.sv
// Two-entry FIFO; head register keeps its last value once the FIFO drains.
module dispatch_fifo2
  import dispatch_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head_data,
  output logic              head_valid,
  output logic              full
);

  logic [DATA_W-1:0] head_q, head_d;
  logic [DATA_W-1:0] tail_q, tail_d;
  logic [1:0]        count_q, count_d;
  logic              do_push, do_pop;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    do_push = push && (count_q != 2'd2);
    do_pop  = pop && (count_q != 2'd0);
    if (do_push && do_pop) begin
      // At count 1 the new beat replaces the departing head directly.
      if (count_q == 2'd1) begin
        head_d = push_data;
      end else begin
        head_d = tail_q;
        tail_d = push_data;
      end
    end else if (do_pop) begin
      if (count_q == 2'd2) head_d = tail_q;
      count_d = count_q - 2'd1;
    end else if (do_push) begin
      if (count_q == 2'd0) head_d = push_data;
      else                 tail_d = push_data;
      count_d = count_q + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= 2'd0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign head_data  = head_q;
  assign head_valid = (count_q != 2'd0);
  assign full       = (count_q == 2'd2);

endmodule

// File: rtl/stream_dispatch_1to2.sv
// Routes one valid/ready stream to two buffered outputs by select or round-robin,
// keeping a wrapping beat count per output.
module stream_dispatch_1to2
  import dispatch_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int MODE   = MODE_SEL,
  parameter int CNT_W  = DEF_CNT_W
) (
  input logic                   clk,
  input logic                   rst_n,
  stream_dispatch_1to2_if.slave bus
);

  dest_t      dest;
  logic       accept;
  logic       rr_ptr_q, rr_ptr_d;
  logic [1:0] push;
  logic [1:0] pop;
  logic [1:0] full;
  logic [1:0] head_valid;

  // in_ready looks only at the destination buffer, never at out_ready.
  always_comb begin
    dest       = (MODE == MODE_RR) ? dest_t'(rr_ptr_q) : dest_t'(bus.in_sel);
    accept     = bus.in_valid && !full[dest];
    push       = 2'b00;
    push[dest] = accept;
    rr_ptr_d   = rr_ptr_q;
    if ((MODE == MODE_RR) && accept) rr_ptr_d = ~rr_ptr_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rr_ptr_q <= 1'b0;
    else        rr_ptr_q <= rr_ptr_d;
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_out
    logic [DATA_W-1:0] head_data;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    assign pop[gi] = head_valid[gi] && bus.out_ready[gi];

    dispatch_fifo2 #(.DATA_W(DATA_W)) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push[gi]),
      .push_data (bus.in_data),
      .pop       (pop[gi]),
      .head_data (head_data),
      .head_valid(head_valid[gi]),
      .full      (full[gi])
    );

    always_comb begin
      cnt_d = cnt_q;
      if (push[gi]) cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
    end
  end

  assign bus.in_ready  = !full[dest];
  assign bus.out_valid = head_valid;
  assign bus.out_data0 = g_out[0].head_data;
  assign bus.out_data1 = g_out[1].head_data;
  assign bus.cnt0      = g_out[0].cnt_q;
  assign bus.cnt1      = g_out[1].cnt_q;

endmodule

// File: tb/tb_stream_dispatch_1to2.sv
// Scoreboard bench: u_sel (select mode, 4-bit counters) and u_rr (round-robin mode).
module tb_stream_dispatch_1to2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  logic [7:0] q_s0[$];
  logic [7:0] q_s1[$];
  logic [7:0] q_r0[$];
  logic [7:0] q_r1[$];

  always #5 clk = ~clk;

  stream_dispatch_1to2_if #(.DATA_W(8), .CNT_W(4))  if_s();
  stream_dispatch_1to2_if #(.DATA_W(8), .CNT_W(16)) if_r();

  stream_dispatch_1to2 #(.DATA_W(8), .MODE(0), .CNT_W(4)) u_sel (
    .clk(clk), .rst_n(rst_n), .bus(if_s.slave)
  );

  stream_dispatch_1to2 #(.DATA_W(8), .MODE(1), .CNT_W(16)) u_rr (
    .clk(clk), .rst_n(rst_n), .bus(if_r.slave)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input int inst, input int dest, input logic [7:0] d);
    if (inst == 0 && dest == 0) q_s0.push_back(d);
    else if (inst == 0)         q_s1.push_back(d);
    else if (dest == 0)         q_r0.push_back(d);
    else                        q_r1.push_back(d);
  endtask

  task automatic mon_pop(input int inst, input int port, input logic [7:0] d);
    logic [7:0] exp;
    int         n;
    if (inst == 0 && port == 0)      n = q_s0.size();
    else if (inst == 0)              n = q_s1.size();
    else if (port == 0)              n = q_r0.size();
    else                             n = q_r1.size();
    $display("pop  inst%0d out%0d data=%02h", inst, port, d);
    if (n == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_pop inst%0d out%0d: got %02h expected none", inst, port, d);
    end else begin
      if (inst == 0 && port == 0)      exp = q_s0.pop_front();
      else if (inst == 0)              exp = q_s1.pop_front();
      else if (port == 0)              exp = q_r0.pop_front();
      else                             exp = q_r1.pop_front();
      check($sformatf("pop_data inst%0d out%0d", inst, port), 32'(d), 32'(exp));
    end
  endtask

  // Transfers happen at the next posedge; negedge sees the settled handshake.
  always @(negedge clk) begin
    if (rst_n) begin
      if (if_s.out_valid[0] && if_s.out_ready[0]) mon_pop(0, 0, if_s.out_data0);
      if (if_s.out_valid[1] && if_s.out_ready[1]) mon_pop(0, 1, if_s.out_data1);
      if (if_r.out_valid[0] && if_r.out_ready[0]) mon_pop(1, 0, if_r.out_data0);
      if (if_r.out_valid[1] && if_r.out_ready[1]) mon_pop(1, 1, if_r.out_data1);
    end
  end

  task automatic drive(input int inst, input logic v, input logic sel,
                       input logic [7:0] d, input logic [1:0] rdy);
    @(posedge clk);
    #1;
    if (inst == 0) begin
      if_s.in_valid = v; if_s.in_sel = sel; if_s.in_data = d; if_s.out_ready = rdy;
    end else begin
      if_r.in_valid = v; if_r.in_sel = sel; if_r.in_data = d; if_r.out_ready = rdy;
    end
    @(negedge clk);
  endtask

  task automatic beat(input int inst, input logic sel, input logic [7:0] d,
                      input logic [1:0] rdy, input logic exp_rdy, input int dest);
    logic act;
    drive(inst, 1'b1, sel, d, rdy);
    act = (inst == 0) ? if_s.in_ready : if_r.in_ready;
    $display("beat inst%0d sel=%0d data=%02h in_ready=%0d", inst, sel, d, act);
    check($sformatf("in_ready inst%0d data %02h", inst, d), 32'(act), 32'(exp_rdy));
    if (exp_rdy) push_exp(inst, dest, d);
  endtask

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int wait_cnt;
    if_s.in_valid = 0; if_s.in_sel = 0; if_s.in_data = 0; if_s.out_ready = 0;
    if_r.in_valid = 0; if_r.in_sel = 0; if_r.in_data = 0; if_r.out_ready = 0;
    repeat (2) @(negedge clk);
    check("rst out_valid_s", 32'(if_s.out_valid), 32'h0);
    check("rst out_data0_s", 32'(if_s.out_data0), 32'h0);
    check("rst out_data1_s", 32'(if_s.out_data1), 32'h0);
    check("rst cnt0_s",      32'(if_s.cnt0), 32'h0);
    check("rst in_ready_s",  32'(if_s.in_ready), 32'h1);
    check("rst out_valid_r", 32'(if_r.out_valid), 32'h0);
    check("rst cnt1_r",      32'(if_r.cnt1), 32'h0);
    check("rst in_ready_r",  32'(if_r.in_ready), 32'h1);
    rst_n = 1'b1;

    // Select mode, both consumers ready: one-cycle latency to each output.
    beat(0, 1'b0, 8'h11, 2'b11, 1'b1, 0);
    beat(0, 1'b1, 8'h22, 2'b11, 1'b1, 1);
    check("t1 out_valid c2", 32'(if_s.out_valid), 32'h1);
    check("t1 out_data0 c2", 32'(if_s.out_data0), 32'h11);
    beat(0, 1'b0, 8'h33, 2'b11, 1'b1, 0);
    check("t1 out_valid c3", 32'(if_s.out_valid), 32'h2);
    check("t1 out_data1 c3", 32'(if_s.out_data1), 32'h22);
    drive(0, 1'b0, 1'b0, 8'h00, 2'b11);
    check("t1 out_valid c4", 32'(if_s.out_valid), 32'h1);
    check("t1 out_data0 c4", 32'(if_s.out_data0), 32'h33);
    drive(0, 1'b0, 1'b0, 8'h00, 2'b11);
    check("t1 out_valid empty", 32'(if_s.out_valid), 32'h0);
    check("t1 out_data0 held", 32'(if_s.out_data0), 32'h33);
    check("t1 cnt0", 32'(if_s.cnt0), 32'd2);
    check("t1 cnt1", 32'(if_s.cnt1), 32'd1);

    // out0 stalled: fills at two, out1 still accepts, then ordered drain.
    beat(0, 1'b0, 8'hA1, 2'b10, 1'b1, 0);
    beat(0, 1'b0, 8'hA2, 2'b10, 1'b1, 0);
    beat(0, 1'b0, 8'hA3, 2'b10, 1'b0, 0);
    check("t2 stall data0", 32'(if_s.out_data0), 32'hA1);
    beat(0, 1'b1, 8'hB1, 2'b10, 1'b1, 1);
    drive(0, 1'b0, 1'b0, 8'h00, 2'b10);
    check("t2 stall valid0", 32'(if_s.out_valid[0]), 32'h1);
    check("t2 stable data0", 32'(if_s.out_data0), 32'hA1);
    drive(0, 1'b0, 1'b0, 8'h00, 2'b11);
    beat(0, 1'b0, 8'hA3, 2'b11, 1'b1, 0);
    repeat (2) drive(0, 1'b0, 1'b0, 8'h00, 2'b11);
    check("t2 cnt0", 32'(if_s.cnt0), 32'd5);
    check("t2 cnt1", 32'(if_s.cnt1), 32'd2);

    // Push and pop together at count 1.
    drive(0, 1'b0, 1'b0, 8'h00, 2'b00);
    beat(0, 1'b0, 8'h10, 2'b00, 1'b1, 0);
    drive(0, 1'b0, 1'b0, 8'h00, 2'b00);
    check("t4 head before", 32'(if_s.out_data0), 32'h10);
    beat(0, 1'b0, 8'h20, 2'b01, 1'b1, 0);
    drive(0, 1'b0, 1'b0, 8'h00, 2'b01);
    check("t4 valid after", 32'(if_s.out_valid), 32'h1);
    check("t4 head after", 32'(if_s.out_data0), 32'h20);
    drive(0, 1'b0, 1'b0, 8'h00, 2'b01);
    check("t4 drained", 32'(if_s.out_valid), 32'h0);
    check("t4 cnt0", 32'(if_s.cnt0), 32'd7);

    // 4-bit counter wrap: 7 + 9 beats = 16 -> 0.
    for (int i = 0; i < 9; i++) begin
      beat(0, 1'b0, 8'h40 + 8'(i), 2'b11, 1'b1, 0);
      if (i == 8) check("t5 cnt0 pre-wrap", 32'(if_s.cnt0), 32'd15);
    end
    drive(0, 1'b0, 1'b0, 8'h00, 2'b11);
    check("t5 cnt0 wrapped", 32'(if_s.cnt0), 32'd0);
    check("t5 cnt1 untouched", 32'(if_s.cnt1), 32'd2);
    repeat (2) drive(0, 1'b0, 1'b0, 8'h00, 2'b11);

    // Round-robin mode; in_sel deliberately contradicts the pointer.
    beat(1, 1'b1, 8'h01, 2'b11, 1'b1, 0);
    beat(1, 1'b0, 8'h02, 2'b11, 1'b1, 1);
    beat(1, 1'b1, 8'h03, 2'b11, 1'b1, 0);
    beat(1, 1'b0, 8'h04, 2'b11, 1'b1, 1);
    beat(1, 1'b1, 8'h0A, 2'b01, 1'b1, 0);
    beat(1, 1'b0, 8'h0B, 2'b01, 1'b1, 1);
    beat(1, 1'b1, 8'h0C, 2'b01, 1'b1, 0);
    beat(1, 1'b0, 8'h05, 2'b01, 1'b0, 1);
    beat(1, 1'b0, 8'h05, 2'b01, 1'b0, 1);
    check("t3 stall data1", 32'(if_r.out_data1), 32'h04);
    check("t3 stall cnt1", 32'(if_r.cnt1), 32'd3);
    beat(1, 1'b0, 8'h05, 2'b11, 1'b0, 1);
    beat(1, 1'b0, 8'h05, 2'b11, 1'b1, 1);
    beat(1, 1'b1, 8'h06, 2'b11, 1'b1, 0);
    repeat (4) drive(1, 1'b0, 1'b0, 8'h00, 2'b11);
    check("t3 cnt0", 32'(if_r.cnt0), 32'd5);
    check("t3 cnt1", 32'(if_r.cnt1), 32'd4);

    // Fill both buffers, reset mid-cycle, and expect nothing to emerge.
    beat(0, 1'b0, 8'hC1, 2'b00, 1'b1, 0);
    beat(0, 1'b0, 8'hC2, 2'b00, 1'b1, 0);
    beat(0, 1'b1, 8'hD1, 2'b00, 1'b1, 1);
    beat(0, 1'b1, 8'hD2, 2'b00, 1'b1, 1);
    @(posedge clk);
    #3;
    check("t6 full before rst", 32'(if_s.in_ready), 32'h0);
    rst_n = 1'b0;
    #1;
    q_s0.delete(); q_s1.delete(); q_r0.delete(); q_r1.delete();
    check("t6 rst out_valid", 32'(if_s.out_valid), 32'h0);
    check("t6 rst cnt0", 32'(if_s.cnt0), 32'h0);
    check("t6 rst cnt1", 32'(if_s.cnt1), 32'h0);
    if_s.in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 1'b0, 1'b0, 8'h00, 2'b11);
    check("t6 in_ready after rst", 32'(if_s.in_ready), 32'h1);
    repeat (3) drive(0, 1'b0, 1'b0, 8'h00, 2'b11);
    check("t6 no old data", 32'(if_s.out_valid), 32'h0);
    beat(1, 1'b1, 8'h77, 2'b11, 1'b1, 0);

    wait_cnt = 0;
    while ((q_s0.size() + q_s1.size() + q_r0.size() + q_r1.size()) != 0 && wait_cnt < 50) begin
      drive(1, 1'b0, 1'b0, 8'h00, 2'b11);
      wait_cnt++;
    end
    check("final q_s0 empty", 32'(q_s0.size()), 32'd0);
    check("final q_s1 empty", 32'(q_s1.size()), 32'd0);
    check("final q_r0 empty", 32'(q_r0.size()), 32'd0);
    check("final q_r1 empty", 32'(q_r1.size()), 32'd0);
    check("final cnt0_r", 32'(if_r.cnt0), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
